// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, 8 data bits LSB-first, optional parity,
// then 1 or 2 stop bits on a line that idles high.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic          tx_q;
  logic          busy_q;
  logic          done_q;
  logic          bit_end;

  assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE) begin
        cnt_q <= bit_end ? '0 : cnt_q + CW'(1);
      end
      unique case (state_q)
        IDLE: begin
          if (tx_start) begin
            state_q <= START;
            shift_q <= tx_data;
            par_q   <= (^tx_data) ^ (PARITY_ODD != 0);
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            idx_q   <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_q <= shift_q >> 1;
            if (idx_q == 3'd7) begin
              idx_q <= '0;
              if (PARITY_EN != 0) begin
                state_q <= PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              idx_q <= idx_q + 3'd1;
              tx_q  <= shift_q[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
        end
        STOP: begin
          // idx_q counts stop bits here so 2-stop frames reuse the same counter
          if (bit_end) begin
            if (idx_q == 3'(STOP_BITS - 1)) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Serial UART transmitter directly downstream of the core's MMIO UART port.
- Consumes the one-byte transmit request from the core's MMIO path: tx_start and tx_data.
- Returns busy, which software polls through the MMIO status path before it writes the next byte.
- Frames each byte as start bit, 8 data bits LSB-first, optional parity bit, then 1 or 2 stop bits, on a single-wire line that idles high.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per serial bit (CLK_FREQ/BAUD, e.g. 100 MHz / 115200); legal values >= 2.
- PARITY_EN, 0, 1 inserts a parity bit after data bit 7.
- PARITY_ODD, 0, parity type when PARITY_EN=1: 0 even, 1 odd.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- tx_start  input  1  transmit request, level-sampled; the core drives it as a one-cycle pulse.
- tx_data  input  8  byte to send, sampled only in the cycle a request is accepted.
- tx  output  1  serial line, idle high.
- busy  output  1  registered; high from the cycle after acceptance until the frame completes.
- tx_done  output  1  one-cycle pulse in the cycle busy falls.

Behaviour:
- One clock; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: tx=1, busy=0, tx_done=0, state=IDLE, baud counter=0, bit index=0, shift register=0.
- Acceptance: a request is accepted at an edge where tx_start=1 and busy=0 (state IDLE).
  - tx_data is latched into the shift register on that edge.
  - busy=1 and tx=0 (start bit) are visible from the next cycle.
- Requests while busy=1 are ignored and not queued. No data is latched and the frame in flight is unaffected.
- If tx_start is held high, a new frame is accepted as soon as busy returns low. One byte is sent per acceptance.
- State machine:
  - IDLE -> START on acceptance.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> PARITY (PARITY_EN=1) or STOP after 8 bits.
  - PARITY -> STOP after CLKS_PER_BIT cycles.
  - STOP -> IDLE after STOP_BITS*CLKS_PER_BIT cycles.
- Every bit is held on tx for exactly CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
  - Its width is clog2(CLKS_PER_BIT).
- Data bits are sent LSB first. The 3-bit bit index runs 0..7 and the shift register shifts right once per bit.
- Parity bit = XOR of the 8 latched data bits, XORed with PARITY_ODD.
- busy is high for exactly N*CLKS_PER_BIT cycles, where N = 1 + 8 + PARITY_EN + STOP_BITS (10 for 8N1).
- Completion:
  - On the edge ending the last stop-bit cycle, state goes to IDLE, busy goes to 0 and tx_done pulses for one cycle.
  - tx stays 1 from the end of the stop bit onward.
- Minimum inter-frame gap: one idle cycle. A tx_start in the cycle where busy=0 and tx_done=1 is accepted.
- Reset mid-frame:
  - From the next cycle, tx=1, busy=0 and tx_done=0.
  - The partial frame is abandoned with no completion pulse.
  - A tx_start coincident with reset is ignored.
- Parameter checks: out-of-range CLKS_PER_BIT or STOP_BITS is reported as an elaboration-time error. Behaviour for those values is undefined.

Test Plan:
- CLKS_PER_BIT=4, 8N1, pulse tx_start with tx_data=0x55 -> expected response:
  - tx over 40 cycles = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles.
  - busy high exactly 40 cycles.
  - tx_done pulses once in cycle 41 after acceptance.
- Same config, send 0xA5, then pulse tx_start with 0xFF at cycles 5 and 20 of the frame -> expected response:
  - Serial bits 0,1,0,1,0,0,1,0,1,1.
  - 0xFF never transmitted.
  - busy stays high for 40 cycles.
- PARITY_EN=1, even, send 0xA5 (four ones) -> parity bit 0 and frame length 44 cycles. PARITY_ODD=1 -> parity bit 1.
- STOP_BITS=2, send 0x00 -> expected response:
  - tx low for 36 cycles, then high for 8 cycles.
  - busy high for 44 cycles.
- Hold tx_start=1 with tx_data=0x31 across two frames -> expected response:
  - Second frame starts with exactly one idle cycle (busy=0, tx=1) after the first.
  - Two tx_done pulses, 41 cycles apart.
- Assert reset at cycle 13 of a 0x55 frame -> expected response:
  - Next cycle tx=1, busy=0, tx_done never pulses.
  - A following tx_start with 0x0F sends a clean full frame.
